pulse_event_enc: RTL and testbench

PULSE_EVENT_ENC -- requirements
Module: pulse_event_enc

---
 rtl/pulse_event_enc.sv | 61 ++++++
 tb/tb_pulse_event_enc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_event_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_event_enc: queues per-channel event pulses and emits channel indices  |
// | lowest-first through a one-entry valid/ready stage.  Revision 1.0           |
// +----------------------------------------------------------------------------+
module pulse_event_enc #(
  parameter int N  = 18,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  pulse_in,
  input  logic          out_ready,
  input  logic          ovf_clr,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic          ovf,
  output logic          busy
);

  logic [N-1:0]  pend;
  logic [N-1:0]  clr;
  logic [IW-1:0] low_idx;
  logic          load;
  logic          lost;

  // Scan downward so the last assignment is the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[i]) low_idx = IW'(i);
    end
  end

  assign load = (!out_valid || out_ready) && (pend != '0);
  assign clr  = load ? (pend & ((~pend) + N'(1))) : '0;
  // A pulse on a bit that stays pending is an event we cannot record twice.
  assign lost = |(pulse_in & pend & ~clr);
  assign busy = (pend != '0) | out_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      ovf       <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | pulse_in;
      if (load) begin
        out_valid <= 1'b1;
        out_idx   <= low_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (lost)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_event_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pulse_event_enc: directed stimulus with a queue-based scoreboard.        |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_pulse_event_enc;

  localparam int N  = 18;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  pulse_in;
  logic          out_ready;
  logic          ovf_clr;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic          ovf;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  pulse_event_enc #(.N(N), .IW(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .pulse_in  (pulse_in),
    .out_ready (out_ready),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] ch(input int i);
    logic [N-1:0] one;
    one = N'(1);
    return one << i;
  endfunction

  // Monitor: every accepted event must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      checks++;
      if (int'(out_idx) > N - 1) begin
        errors++;
        $display("FAIL idx_range: got %0d expected <= %0d", out_idx, N - 1);
      end
    end
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got idx %0d expected no event", out_idx);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(out_idx) !== e) begin
          errors++;
          $display("FAIL sb_idx: got %0d expected %0d", out_idx, e);
        end
      end
    end
  end

  initial begin
    int seq[3];
    reset = 1'b0; pulse_in = 18'h3FFFF; out_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    reset = 1'b1; pulse_in = '0;
    check("rst_valid", out_valid, 0);
    check("rst_idx", out_idx, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    tick();
    check("rst_busy_after", busy, 0);

    // Single event with two-cycle latency.
    out_ready = 1'b1;
    pulse_in = ch(7); exp_q.push_back(7);
    tick(); pulse_in = '0;
    check("single_t1_valid", out_valid, 0);
    check("single_t1_busy", busy, 1);
    tick();
    check("single_t2_valid", out_valid, 1);
    check("single_t2_idx", out_idx, 7);
    tick();
    check("single_t3_valid", out_valid, 0);
    check("single_t3_busy", busy, 0);

    // Three simultaneous events emit in ascending order.
    pulse_in = ch(17) | ch(3) | ch(0);
    exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(17);
    tick(); pulse_in = '0;
    tick();
    seq = '{0, 3, 17};
    for (int k = 0; k < 3; k++) begin
      check("multi_valid", out_valid, 1);
      check("multi_idx", out_idx, seq[k]);
      tick();
    end
    check("multi_done", out_valid, 0);

    // Backpressure, plus a re-pulse of the presented channel (not an overflow).
    out_ready = 1'b0;
    pulse_in = ch(5); exp_q.push_back(5);
    tick(); pulse_in = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("bp_valid", out_valid, 1);
      check("bp_idx", out_idx, 5);
      if (k == 1) begin pulse_in = ch(5); exp_q.push_back(5); end
      else pulse_in = '0;
      tick();
    end
    pulse_in = '0;
    check("bp_no_ovf", ovf, 0);
    out_ready = 1'b1;
    tick();
    check("bp_repend_valid", out_valid, 1);
    check("bp_repend_idx", out_idx, 5);
    tick();
    check("bp_done", out_valid, 0);

    // Pulse on a channel being loaded in the same cycle stays pending.
    pulse_in = ch(6); exp_q.push_back(6);
    tick(); pulse_in = ch(6); exp_q.push_back(6);
    tick(); pulse_in = '0;
    check("setwin_idx1", out_idx, 6);
    tick();
    check("setwin_valid2", out_valid, 1);
    check("setwin_idx2", out_idx, 6);
    tick();
    check("setwin_done", out_valid, 0);
    check("setwin_no_ovf", ovf, 0);

    // Overflow: a second ch2 pulse while ch2 is still pending.
    out_ready = 1'b0;
    pulse_in = ch(9); exp_q.push_back(9);
    tick(); pulse_in = '0;
    tick();
    check("ovf_present_idx", out_idx, 9);
    pulse_in = ch(2); exp_q.push_back(2);
    tick(); pulse_in = '0;
    tick();
    check("ovf_first_ch2", ovf, 0);
    pulse_in = ch(2);
    tick(); pulse_in = '0;
    check("ovf_second_ch2", ovf, 1);
    out_ready = 1'b1;
    tick();
    check("ovf_ch2_idx", out_idx, 2);
    tick();
    check("ovf_drain", out_valid, 0);
    tick();
    check("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);

    // Overflow and clear in the same cycle: set wins.
    out_ready = 1'b0;
    pulse_in = ch(4); exp_q.push_back(4);
    tick(); pulse_in = '0;
    tick();
    pulse_in = ch(1); exp_q.push_back(1);
    tick(); pulse_in = ch(1); ovf_clr = 1'b1;
    tick(); pulse_in = '0;
    check("ovf_setwins", ovf, 1);
    tick(); ovf_clr = 1'b0;
    check("ovf_clr2", ovf, 0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("ovf2_drain", out_valid, 0);

    // Reset mid-operation drops presented and pending events.
    out_ready = 1'b0;
    pulse_in = ch(1) | ch(2) | ch(3) | ch(4);
    tick(); pulse_in = '0;
    tick();
    check("midrst_pre_valid", out_valid, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1; out_ready = 1'b1;
    check("midrst_valid", out_valid, 0);
    check("midrst_idx", out_idx, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_busy", busy, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("midrst_quiet", out_valid, 0);
    end

    // First cycle after release captures normally.
    reset = 1'b0;
    tick();
    reset = 1'b1; pulse_in = ch(11); exp_q.push_back(11);
    tick(); pulse_in = '0;
    tick();
    check("postrst_valid", out_valid, 1);
    check("postrst_idx", out_idx, 11);
    tick(); tick();
    check("final_idle", busy, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
